// File: rtl/hpi_responder.sv
// HPI host-port responder: 16-bit host register window onto a local RAM plus two mailboxes.
// Latency: writes commit on the first strobe edge; read data is valid one edge after the read starts.
// Backpressure: none; the host holds read strobes >= 2 cycles, and the mailboxes overwrite when full.
module hpi_responder #(
  parameter int ADDR_W = 8
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        otg_hpi_reset_n,
  input  logic [1:0]  otg_hpi_address,
  input  logic        otg_hpi_cs_n,
  input  logic        otg_hpi_r_n,
  input  logic        otg_hpi_w_n,
  input  logic [15:0] otg_hpi_data_in,
  output logic [15:0] otg_hpi_data_out,
  output logic [15:0] mbx_rx_data,
  output logic        mbx_rx_valid,
  input  logic        mbx_rx_ack,
  input  logic [15:0] mbx_tx_data,
  input  logic        mbx_tx_wr,
  output logic        irq
);

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_MBX  = 2'd1;
  localparam logic [1:0] REG_ADDR = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  // addr is a byte address; bit 0 is always 0 and the RAM is word-indexed by addr[ADDR_W:1]
  localparam logic [ADDR_W:0] ADDR_STEP = (ADDR_W + 1)'(2);

  logic [15:0]     ram [0:(1 << ADDR_W) - 1];
  logic [15:0]     ram_q;

  logic            rst;
  logic            acc_w;
  logic            acc_r;
  logic            clash;
  logic            prev_w;
  logic            prev_r;
  logic            wr_commit;
  logic            rd_start;
  logic            rd_end;
  logic            rd_hold;

  logic [ADDR_W:0] addr;
  logic            err;
  logic            ovr;
  logic [15:0]     tx_data;
  logic            tx_full;
  logic [1:0]      rd_src;
  logic [15:0]     rd_reg;
  logic [15:0]     rd_mux;
  logic [15:0]     dout;
  logic [15:0]     status;

  // Either reset source clears the block at the next edge
  assign rst = !reset_reset_n || !otg_hpi_reset_n;

  assign acc_w = !otg_hpi_cs_n && !otg_hpi_w_n && otg_hpi_r_n;
  assign acc_r = !otg_hpi_cs_n && !otg_hpi_r_n && otg_hpi_w_n;
  assign clash = !otg_hpi_cs_n && !otg_hpi_r_n && !otg_hpi_w_n;

  // Edge detection on the strobes; a clash cycle ends no read, so the abandoned read has no side effects
  assign wr_commit = acc_w && !prev_w;
  assign rd_start  = acc_r && !prev_r;
  assign rd_hold   = acc_r && prev_r;
  assign rd_end    = !acc_r && prev_r && !clash;

  assign status = {err, ovr, 12'b0, mbx_rx_valid, tx_full};
  assign irq    = tx_full;

  // Output is forced to zero whenever no read strobe is present
  assign otg_hpi_data_out = acc_r ? dout : 16'h0000;

  // Non-RAM read source, chosen from the host address at read start
  always_comb begin
    rd_mux = 16'h0000;
    case (otg_hpi_address)
      REG_MBX:  rd_mux = tx_data;
      REG_ADDR: rd_mux = 16'(addr);
      REG_STAT: rd_mux = status;
      default:  rd_mux = 16'h0000;
    endcase
  end

  // RAM port: contents never reset; accesses during reset are dropped
  always_ff @(posedge clk_clk) begin
    if (!rst && wr_commit && otg_hpi_address == REG_DATA) begin
      ram[addr[ADDR_W:1]] <= otg_hpi_data_in;
    end
    if (!rst && rd_start) begin
      ram_q <= ram[addr[ADDR_W:1]];
    end
  end

  // Strobe history
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      prev_w <= 1'b0;
      prev_r <= 1'b0;
    end else begin
      prev_w <= acc_w;
      prev_r <= acc_r;
    end
  end

  // Read capture at start, then registered output held while the strobe stays low
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      rd_src <= REG_DATA;
      rd_reg <= 16'h0000;
      dout   <= 16'h0000;
    end else begin
      if (rd_start) begin
        rd_src <= otg_hpi_address;
        rd_reg <= rd_mux;
      end
      if (rd_hold) begin
        dout <= (rd_src == REG_DATA) ? ram_q : rd_reg;
      end else begin
        dout <= 16'h0000;
      end
    end
  end

  // Address pointer: loaded by ADDRESS writes, post-incremented by DATA writes and DATA read ends
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      addr <= '0;
    end else if (wr_commit && otg_hpi_address == REG_ADDR) begin
      addr <= {otg_hpi_data_in[ADDR_W:1], 1'b0};
    end else if (wr_commit && otg_hpi_address == REG_DATA) begin
      addr <= addr + ADDR_STEP;
    end else if (rd_end && rd_src == REG_DATA) begin
      addr <= addr + ADDR_STEP;
    end
  end

  // Host-to-local mailbox; a host write beats a same-edge local ack
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      mbx_rx_data  <= 16'h0000;
      mbx_rx_valid <= 1'b0;
    end else if (wr_commit && otg_hpi_address == REG_MBX) begin
      mbx_rx_data  <= otg_hpi_data_in;
      mbx_rx_valid <= 1'b1;
    end else if (mbx_rx_ack) begin
      mbx_rx_valid <= 1'b0;
    end
  end

  // Local-to-host mailbox; a local write beats a same-edge host read-end clear
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      tx_data <= 16'h0000;
      tx_full <= 1'b0;
    end else if (mbx_tx_wr) begin
      tx_data <= mbx_tx_data;
      tx_full <= 1'b1;
    end else if (rd_end && rd_src == REG_MBX) begin
      tx_full <= 1'b0;
    end
  end

  // Sticky error/overrun flags, cleared when a STATUS read ends; a new event wins over the clear
  always_ff @(posedge clk_clk) begin
    if (rst) begin
      err <= 1'b0;
      ovr <= 1'b0;
    end else begin
      if (clash) begin
        err <= 1'b1;
      end else if (rd_end && rd_src == REG_STAT) begin
        err <= 1'b0;
      end
      if (wr_commit && otg_hpi_address == REG_MBX && mbx_rx_valid) begin
        ovr <= 1'b1;
      end else if (rd_end && rd_src == REG_STAT) begin
        ovr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_hpi_responder.sv
// Directed bench for hpi_responder: table of host register accesses plus hand-written mailbox,
// clash and reset sequences. Inputs change and outputs are sampled on the falling clock edge.
module tb_hpi_responder;

  logic        clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        otg_hpi_reset_n = 1'b1;
  logic [1:0]  otg_hpi_address = 2'd0;
  logic        otg_hpi_cs_n = 1'b1;
  logic        otg_hpi_r_n = 1'b1;
  logic        otg_hpi_w_n = 1'b1;
  logic [15:0] otg_hpi_data_in = 16'h0000;
  logic [15:0] otg_hpi_data_out;
  logic [15:0] mbx_rx_data;
  logic        mbx_rx_valid;
  logic        mbx_rx_ack = 1'b0;
  logic [15:0] mbx_tx_data = 16'h0000;
  logic        mbx_tx_wr = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_MBX  = 2'd1;
  localparam logic [1:0] A_ADDR = 2'd2;
  localparam logic [1:0] A_STAT = 2'd3;

  typedef struct {
    bit          rd;
    logic [1:0]  a;
    logic [15:0] v;
  } vec_t;

  vec_t vecs [18];

  hpi_responder #(.ADDR_W(8)) dut (
    .clk_clk          (clk),
    .reset_reset_n    (reset_reset_n),
    .otg_hpi_reset_n  (otg_hpi_reset_n),
    .otg_hpi_address  (otg_hpi_address),
    .otg_hpi_cs_n     (otg_hpi_cs_n),
    .otg_hpi_r_n      (otg_hpi_r_n),
    .otg_hpi_w_n      (otg_hpi_w_n),
    .otg_hpi_data_in  (otg_hpi_data_in),
    .otg_hpi_data_out (otg_hpi_data_out),
    .mbx_rx_data      (mbx_rx_data),
    .mbx_rx_valid     (mbx_rx_valid),
    .mbx_rx_ack       (mbx_rx_ack),
    .mbx_tx_data      (mbx_tx_data),
    .mbx_tx_wr        (mbx_tx_wr),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic host_wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_w_n = 1'b0;
    otg_hpi_address = a;
    otg_hpi_data_in = d;
    @(negedge clk);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_w_n = 1'b1;
  endtask

  task automatic host_rd(input logic [1:0] a, output logic [15:0] v);
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_r_n = 1'b0;
    otg_hpi_address = a;
    @(negedge clk);
    @(negedge clk);
    v = otg_hpi_data_out;
    otg_hpi_cs_n = 1'b1;
    otg_hpi_r_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic tx_pulse(input logic [15:0] d);
    @(negedge clk);
    mbx_tx_data = d;
    mbx_tx_wr = 1'b1;
    @(negedge clk);
    mbx_tx_wr = 1'b0;
  endtask

  initial begin
    logic [15:0] v;

    vecs[0]  = '{1'b0, A_ADDR, 16'h0010};
    vecs[1]  = '{1'b0, A_DATA, 16'hBEEF};
    vecs[2]  = '{1'b0, A_DATA, 16'h1234};
    vecs[3]  = '{1'b0, A_ADDR, 16'h0010};
    vecs[4]  = '{1'b1, A_DATA, 16'hBEEF};
    vecs[5]  = '{1'b1, A_DATA, 16'h1234};
    vecs[6]  = '{1'b1, A_ADDR, 16'h0014};
    vecs[7]  = '{1'b0, A_ADDR, 16'h01FE};
    vecs[8]  = '{1'b0, A_DATA, 16'hCAFE};
    vecs[9]  = '{1'b1, A_ADDR, 16'h0000};
    vecs[10] = '{1'b0, A_ADDR, 16'h01FE};
    vecs[11] = '{1'b1, A_DATA, 16'hCAFE};
    vecs[12] = '{1'b1, A_STAT, 16'h0000};
    vecs[13] = '{1'b0, A_STAT, 16'hFFFF};
    vecs[14] = '{1'b1, A_STAT, 16'h0000};
    vecs[15] = '{1'b0, A_ADDR, 16'h0033};
    vecs[16] = '{1'b1, A_ADDR, 16'h0032};
    vecs[17] = '{1'b0, A_ADDR, 16'hFE10};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_dout", otg_hpi_data_out, 16'h0000);
    reset_reset_n = 1'b1;
    @(negedge clk);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_rx_valid", {15'b0, mbx_rx_valid}, 16'h0000);
    chk("rst_rx_data", mbx_rx_data, 16'h0000);
    host_rd(A_ADDR, v);
    chk("rst_addr", v, 16'h0000);
    host_rd(A_STAT, v);
    chk("rst_status", v, 16'h0000);

    // Table of register accesses
    for (int i = 0; i < 18; i++) begin
      if (vecs[i].rd) begin
        host_rd(vecs[i].a, v);
        chk($sformatf("vec%0d", i), v, vecs[i].v);
      end else begin
        host_wr(vecs[i].a, vecs[i].v);
      end
    end
    host_rd(A_ADDR, v);
    chk("addr_high_bits_dropped", v, 16'h0010);
    chk("idle_dout", otg_hpi_data_out, 16'h0000);

    // Host-to-local mailbox, overrun and ack
    host_wr(A_MBX, 16'h00A5);
    chk("rx_data_a5", mbx_rx_data, 16'h00A5);
    chk("rx_valid_set", {15'b0, mbx_rx_valid}, 16'h0001);
    host_rd(A_STAT, v);
    chk("status_rx", v, 16'h0002);
    host_wr(A_MBX, 16'h00A6);
    chk("rx_data_a6", mbx_rx_data, 16'h00A6);
    host_rd(A_STAT, v);
    chk("status_ovr", v, 16'h4002);
    @(negedge clk);
    mbx_rx_ack = 1'b1;
    @(negedge clk);
    mbx_rx_ack = 1'b0;
    chk("rx_valid_ack", {15'b0, mbx_rx_valid}, 16'h0000);
    host_rd(A_STAT, v);
    chk("status_after_ack", v, 16'h0000);

    // Host write and local ack on the same edge: write wins
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_w_n = 1'b0;
    otg_hpi_address = A_MBX;
    otg_hpi_data_in = 16'h0077;
    mbx_rx_ack = 1'b1;
    @(negedge clk);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_w_n = 1'b1;
    mbx_rx_ack = 1'b0;
    chk("ack_vs_wr_valid", {15'b0, mbx_rx_valid}, 16'h0001);
    chk("ack_vs_wr_data", mbx_rx_data, 16'h0077);
    @(negedge clk);
    mbx_rx_ack = 1'b1;
    @(negedge clk);
    mbx_rx_ack = 1'b0;

    // Local-to-host mailbox and irq timing
    tx_pulse(16'h5A5A);
    chk("irq_set", {15'b0, irq}, 16'h0001);
    host_rd(A_STAT, v);
    chk("status_tx", v, 16'h0001);
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_r_n = 1'b0;
    otg_hpi_address = A_MBX;
    @(negedge clk);
    @(negedge clk);
    chk("mbx_read", otg_hpi_data_out, 16'h5A5A);
    chk("irq_during_read", {15'b0, irq}, 16'h0001);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_r_n = 1'b1;
    @(negedge clk);
    chk("irq_clear", {15'b0, irq}, 16'h0000);

    // MAILBOX read-end and local write on the same edge
    tx_pulse(16'h2222);
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_r_n = 1'b0;
    otg_hpi_address = A_MBX;
    @(negedge clk);
    @(negedge clk);
    chk("mbx_read_2222", otg_hpi_data_out, 16'h2222);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_r_n = 1'b1;
    mbx_tx_data = 16'h3333;
    mbx_tx_wr = 1'b1;
    @(negedge clk);
    mbx_tx_wr = 1'b0;
    chk("irq_race_kept", {15'b0, irq}, 16'h0001);
    host_rd(A_MBX, v);
    chk("mbx_race_data", v, 16'h3333);
    chk("irq_race_clear", {15'b0, irq}, 16'h0000);

    // Strobe clash: an abandoned DATA read and a clash with write data present
    host_wr(A_ADDR, 16'h0010);
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_r_n = 1'b0;
    otg_hpi_address = A_DATA;
    otg_hpi_data_in = 16'hDEAD;
    @(negedge clk);
    @(negedge clk);
    otg_hpi_w_n = 1'b0;
    @(negedge clk);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_r_n = 1'b1;
    otg_hpi_w_n = 1'b1;
    @(negedge clk);
    host_rd(A_ADDR, v);
    chk("clash_addr", v, 16'h0010);
    host_rd(A_STAT, v);
    chk("clash_status", v, 16'h8000);
    host_rd(A_STAT, v);
    chk("clash_status_clr", v, 16'h0000);
    host_rd(A_DATA, v);
    chk("clash_ram", v, 16'hBEEF);

    // Reset in the middle of a DATA read
    tx_pulse(16'h0001);
    host_wr(A_ADDR, 16'h0020);
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_r_n = 1'b0;
    otg_hpi_address = A_DATA;
    @(negedge clk);
    @(negedge clk);
    reset_reset_n = 1'b0;
    @(negedge clk);
    chk("midrd_rst_dout", otg_hpi_data_out, 16'h0000);
    chk("midrd_rst_irq", {15'b0, irq}, 16'h0000);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_r_n = 1'b1;
    reset_reset_n = 1'b1;
    @(negedge clk);
    host_rd(A_ADDR, v);
    chk("midrd_rst_addr", v, 16'h0000);
    host_wr(A_ADDR, 16'h0010);
    host_rd(A_DATA, v);
    chk("ram_retained", v, 16'hBEEF);

    // Host soft reset
    tx_pulse(16'h0002);
    host_wr(A_ADDR, 16'h0040);
    @(negedge clk);
    otg_hpi_reset_n = 1'b0;
    @(negedge clk);
    otg_hpi_reset_n = 1'b1;
    chk("soft_rst_irq", {15'b0, irq}, 16'h0000);
    host_rd(A_ADDR, v);
    chk("soft_rst_addr", v, 16'h0000);

    // Write strobe held through reset counts as a new access after release
    @(negedge clk);
    otg_hpi_cs_n = 1'b0;
    otg_hpi_w_n = 1'b0;
    otg_hpi_address = A_ADDR;
    otg_hpi_data_in = 16'h0050;
    reset_reset_n = 1'b0;
    @(negedge clk);
    reset_reset_n = 1'b1;
    @(negedge clk);
    otg_hpi_cs_n = 1'b1;
    otg_hpi_w_n = 1'b1;
    host_rd(A_ADDR, v);
    chk("held_strobe_after_rst", v, 16'h0050);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hpi_responder.md
HPI_RESPONDER -- requirements
Module: hpi_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning internal RAM word-address width (depth 2^ADDR_W x 16).
REQ-002 The block SHALL have port clk_clk, input, 1, the single clock.
REQ-003 The block SHALL have port reset_reset_n, input, 1, reset that is synchronous and active-low.
REQ-004 The block SHALL have port otg_hpi_reset_n, input, 1, host-driven soft reset, active-low, synchronous.
REQ-005 The block SHALL have port otg_hpi_address, input, 2, register select: 0=DATA, 1=MAILBOX, 2=ADDRESS, 3=STATUS.
REQ-006 The block SHALL have port otg_hpi_cs_n, input, 1, chip select, active-low.
REQ-007 The block SHALL have ports otg_hpi_r_n and otg_hpi_w_n, input, 1 each, read and write strobes, active-low.
REQ-008 The block SHALL have port otg_hpi_data_in, input, 16, write data from the host.
REQ-009 The block SHALL have port otg_hpi_data_out, output, 16, read data to the host.
REQ-010 The block SHALL have ports mbx_rx_data (output, 16), mbx_rx_valid (output, 1) and mbx_rx_ack (input, 1), carrying the host-to-local mailbox.
REQ-011 The block SHALL have ports mbx_tx_data (input, 16) and mbx_tx_wr (input, 1), carrying the local-to-host mailbox write.
REQ-012 The block SHALL have port irq, output, 1, asserted while the local-to-host mailbox is full.

Function
REQ-013 Strobe definitions SHALL be acc_w = !cs_n & !w_n & r_n and acc_r = !cs_n & !r_n & w_n, each registered to give a one-cycle previous value.
REQ-014 A write SHALL commit at the first edge where acc_w=1 and prev=0, capturing otg_hpi_data_in at that edge, with exactly one commit per strobe assertion.
REQ-015 A write to ADDRESS SHALL load addr <= {data_in[ADDR_W:1],1'b0}, zero-extended, with bit0 forced to 0.
REQ-016 A write to DATA SHALL write RAM[addr[ADDR_W:1]] and, at the same edge, increment addr by 2 modulo 2^(ADDR_W+1).
REQ-017 A write to MAILBOX SHALL load mbx_rx_data and set mbx_rx_valid=1; if valid was already 1, data SHALL be overwritten and sticky STATUS[14] (overrun) set.
REQ-018 A write to STATUS SHALL be ignored.
REQ-019 A read SHALL begin at the first edge where acc_r=1 and prev=0, issuing the RAM read and selecting the source register.
REQ-020 otg_hpi_data_out SHALL be valid from the next edge (1-cycle latency) and held while acc_r=1; the host holds r_n low for at least 2 cycles.
REQ-021 otg_hpi_data_out SHALL be 16'h0000 whenever acc_r=0.
REQ-022 A read SHALL end at the first edge where acc_r=0 after acc_r=1, and the following side effects SHALL occur only at read end:
- DATA: addr += 2, with the same wrap as REQ-016.
- MAILBOX: returns tx mailbox; clears tx_full.
- STATUS: clears STATUS[15:14].
REQ-023 The read sources SHALL be: ADDRESS returns addr zero-extended; STATUS returns {err, ovr, 12'b0, rx_valid, tx_full}.
REQ-024 A mbx_tx_wr pulse SHALL load the tx mailbox from mbx_tx_data and set tx_full=1, overwriting the mailbox if already full.
REQ-025 A host MAILBOX read-end and mbx_tx_wr on the same edge SHALL leave tx_full=1 holding the new data.
REQ-026 mbx_rx_ack SHALL clear mbx_rx_valid; if ack and a host MAILBOX write occur on the same edge, the write SHALL win (valid=1, new data).
REQ-027 irq SHALL equal tx_full, registered, with no extra latency beyond the tx_full register.
REQ-028 If cs_n=0, r_n=0 and w_n=0 are sampled together, the block SHALL set sticky STATUS[15] (err) and make no other state change; an access in progress SHALL be abandoned without side effects.
REQ-029 cs_n=1 SHALL make all strobes inactive; if deasserted mid-read, the read-end effects of REQ-022 SHALL apply.

Reset
REQ-030 On reset_reset_n=0 or otg_hpi_reset_n=0 at a clock edge, the block SHALL clear addr=0, otg_hpi_data_out=0, mbx_rx_data=0, mbx_rx_valid=0, tx_full=0, irq=0, STATUS[15:14]=0 and the strobe history.
REQ-031 RAM contents SHALL be retained through reset and SHALL NOT be initialised.
REQ-032 An access in progress during reset SHALL be dropped, with no commit or increment; after reset release, a strobe still held low SHALL count as a new access start.

Verification
REQ-033 The bench SHALL cover: ADDRESS<=0x0010, DATA<=0xBEEF, DATA<=0x1234, ADDRESS<=0x0010, read DATA twice -> 0xBEEF then 0x1234; ADDRESS read -> 0x0014.
REQ-034 The bench SHALL cover: ADDRESS<=0x01FE (ADDR_W=8), DATA<=0xCAFE -> ADDRESS reads 0x0000; ADDRESS<=0x01FE, read DATA -> 0xCAFE.
REQ-035 The bench SHALL cover: host MAILBOX<=0x00A5 -> mbx_rx_data=0x00A5, valid=1, STATUS=0x0002; second write 0x00A6 before ack -> STATUS=0x4002; pulse ack -> valid=0.
REQ-036 The bench SHALL cover: mbx_tx_wr with 0x5A5A -> irq=1, STATUS[0]=1; host MAILBOX read -> 0x5A5A; irq=0 one edge after r_n rises.
REQ-037 The bench SHALL cover: cs_n, r_n and w_n all low -> no RAM/addr change, STATUS read -> 0x8000, next STATUS read -> 0x0000.
REQ-038 The bench SHALL cover: reset_reset_n low mid-DATA-read at addr 0x0020 -> data_out=0, addr=0, irq=0; RAM[0x10] still returns its prior value afterwards.
